tri_raster: RTL

TRI_RASTER -- requirements
Module: tri_raster

---
 rtl/gpu_shapes_pkg.sv | 17 +
 rtl/tri_edge_fn.sv | 36 +++
 rtl/tri_raster.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_shapes_pkg.sv
// Shared definitions for the shape rasterisers.
// Holds the FSM encoding and the edge-function width helper.
package gpu_shapes_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SCAN,
        S_FINISH
    } tri_state_t;

    // Two coordinate differences multiplied, subtracted, plus a sign bit.
    function automatic int edge_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

endpackage

// File: rtl/tri_edge_fn.sv
// Edge function of segment a->b evaluated at p,
// plus its per-pixel x and y increments.
module tri_edge_fn
    import gpu_shapes_pkg::*;
#(
    parameter int COORD_W = 8
) (
    input  logic [COORD_W-1:0]                 ax,
    input  logic [COORD_W-1:0]                 ay,
    input  logic [COORD_W-1:0]                 bx,
    input  logic [COORD_W-1:0]                 by,
    input  logic [COORD_W-1:0]                 px,
    input  logic [COORD_W-1:0]                 py,
    output logic signed [edge_w(COORD_W)-1:0] e,
    output logic signed [edge_w(COORD_W)-1:0] step_x,
    output logic signed [edge_w(COORD_W)-1:0] step_y
);

    localparam int EW = edge_w(COORD_W);

    logic signed [EW-1:0] dx;
    logic signed [EW-1:0] dy;
    logic signed [EW-1:0] qx;
    logic signed [EW-1:0] qy;

    always_comb begin
        dx     = EW'(bx) - EW'(ax);
        dy     = EW'(by) - EW'(ay);
        qx     = EW'(px) - EW'(ax);
        qy     = EW'(py) - EW'(ay);
        e      = dx * qy - dy * qx;
        step_x = -dy;
        step_y = dx;
    end

endmodule

// File: rtl/tri_raster.sv
// Scan-converts one triangle over its bounding box using
// incremental edge functions; emits covered pixels over valid/ready.
module tri_raster
    import gpu_shapes_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COLOR_W-1:0] color,
    input  logic               pixel_ready,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               busy,
    output logic               done,
    output logic [2*COORD_W:0] pixel_count
);

    localparam int EW = edge_w(COORD_W);
    localparam int CW = COORD_W + 1;
    localparam int NW = 2 * COORD_W + 1;

    tri_state_t state_q;
    tri_state_t state_d;

    logic [COORD_W-1:0]   vx [3];
    logic [COORD_W-1:0]   vy [3];
    logic [COLOR_W-1:0]   col_q;
    logic [CW-1:0]        minx_q;
    logic [CW-1:0]        maxx_q;
    logic [CW-1:0]        maxy_q;
    logic [CW-1:0]        cx_q;
    logic [CW-1:0]        cy_q;
    logic                 area_neg_q;
    logic                 scan_end_q;
    logic signed [EW-1:0] ec_q [3];
    logic signed [EW-1:0] er_q [3];
    logic signed [EW-1:0] sx_q [3];
    logic signed [EW-1:0] sy_q [3];

    logic signed [EW-1:0] e_c [3];
    logic signed [EW-1:0] sx_c [3];
    logic signed [EW-1:0] sy_c [3];
    logic signed [EW-1:0] area_c;
    logic [COORD_W-1:0]   bminx;
    logic [COORD_W-1:0]   bminy;
    logic [COORD_W-1:0]   bmaxx;
    logic [COORD_W-1:0]   bmaxy;
    logic [2:0]           nonneg;
    logic [2:0]           nonpos;
    logic                 covered;
    logic                 xfer;
    logic                 adv;
    logic                 last;
    logic                 row_end;

    function automatic logic [COORD_W-1:0] min3(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b,
        input logic [COORD_W-1:0] c
    );
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b,
        input logic [COORD_W-1:0] c
    );
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        bminx = min3(vx[0], vx[1], vx[2]);
        bminy = min3(vy[0], vy[1], vy[2]);
        bmaxx = max3(vx[0], vx[1], vx[2]);
        bmaxy = max3(vy[0], vy[1], vy[2]);
    end

    // Twice the signed area: E_01 evaluated at v2.
    always_comb begin
        area_c = (EW'(vx[1]) - EW'(vx[0])) * (EW'(vy[2]) - EW'(vy[0]))
               - (EW'(vy[1]) - EW'(vy[0])) * (EW'(vx[2]) - EW'(vx[0]));
    end

    // Edge g runs from vertex g+1 to g+2: E_12, E_20, E_01.
    for (genvar g = 0; g < 3; g++) begin : g_edge
        tri_edge_fn #(
            .COORD_W(COORD_W)
        ) u_edge (
            .ax    (vx[(g+1)%3]),
            .ay    (vy[(g+1)%3]),
            .bx    (vx[(g+2)%3]),
            .by    (vy[(g+2)%3]),
            .px    (bminx),
            .py    (bminy),
            .e     (e_c[g]),
            .step_x(sx_c[g]),
            .step_y(sy_c[g])
        );
    end

    always_comb begin
        nonneg = '0;
        nonpos = '0;
        for (int i = 0; i < 3; i++) begin
            nonneg[i] = ~ec_q[i][EW-1];
            nonpos[i] = ec_q[i][EW-1] | ~|ec_q[i];
        end
        covered = area_neg_q ? &nonpos : &nonneg;
    end

    always_comb begin
        xfer    = pixel_valid & pixel_ready;
        adv     = (state_q == S_SCAN) & ~scan_end_q
                & (~pixel_valid | pixel_ready);
        row_end = (cx_q == maxx_q);
        last    = row_end & (cy_q == maxy_q);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FINISH);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = (area_c != '0) ? S_SCAN : S_FINISH;
            end
            S_SCAN: begin
                if (scan_end_q && (!pixel_valid || pixel_ready))
                    state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                vx[i]   <= '0;
                vy[i]   <= '0;
                ec_q[i] <= '0;
                er_q[i] <= '0;
                sx_q[i] <= '0;
                sy_q[i] <= '0;
            end
            col_q       <= '0;
            minx_q      <= '0;
            maxx_q      <= '0;
            maxy_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            area_neg_q  <= 1'b0;
            scan_end_q  <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= '0;
            pixel_count <= '0;
        end else begin
            if (xfer) pixel_count <= pixel_count + NW'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        vx[0]       <= x0;
                        vy[0]       <= y0;
                        vx[1]       <= x1;
                        vy[1]       <= y1;
                        vx[2]       <= x2;
                        vy[2]       <= y2;
                        col_q       <= color;
                        pixel_count <= '0;
                        scan_end_q  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    area_neg_q <= area_c[EW-1];
                    minx_q     <= CW'(bminx);
                    maxx_q     <= CW'(bmaxx);
                    maxy_q     <= CW'(bmaxy);
                    cx_q       <= CW'(bminx);
                    cy_q       <= CW'(bminy);
                    for (int i = 0; i < 3; i++) begin
                        ec_q[i] <= e_c[i];
                        er_q[i] <= e_c[i];
                        sx_q[i] <= sx_c[i];
                        sy_q[i] <= sy_c[i];
                    end
                end
                S_SCAN: begin
                    if (adv) begin
                        pixel_valid <= covered;
                        if (covered) begin
                            pixel_x     <= cx_q[COORD_W-1:0];
                            pixel_y     <= cy_q[COORD_W-1:0];
                            pixel_color <= col_q;
                        end
                        // Row start values carry the y-step; x-step runs within a row.
                        if (last) begin
                            scan_end_q <= 1'b1;
                        end else if (row_end) begin
                            cx_q <= minx_q;
                            cy_q <= cy_q + CW'(1);
                            for (int i = 0; i < 3; i++) begin
                                er_q[i] <= er_q[i] + sy_q[i];
                                ec_q[i] <= er_q[i] + sy_q[i];
                            end
                        end else begin
                            cx_q <= cx_q + CW'(1);
                            for (int i = 0; i < 3; i++)
                                ec_q[i] <= ec_q[i] + sx_q[i];
                        end
                    end else if (xfer) begin
                        pixel_valid <= 1'b0;
                    end
                end
                S_FINISH: pixel_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
